mem_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 23 ++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
//   arb_state_t : FSM states (idle, or holding a grant for requester 0 or 1)
//   WR / RD     : encoding of the per-requester write/read select
//   REQ0 / REQ1 : requester indices
//   onehot2     : requester index -> one-hot 2-bit grant vector
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way priority pick.
//   valid : request valid per requester
//   ptr   : index of the currently preferred requester
//   gnt   : one-hot pick; the preferred requester wins if it is valid,
//           otherwise the other one, otherwise nothing
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (valid[ptr]) begin
      gnt = onehot2(ptr);
    end else if (valid[~ptr]) begin
      gnt = onehot2(~ptr);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port valid/ready memory between two
// requesters. One transaction is in flight at a time; the grant is held until
// the memory handshakes or the transaction is aborted after TIMEOUT cycles.
//   clk, rst                : clock, asynchronous active-low reset
//   req_valid_i/req_wr_rd_i : per-requester request valid and write(1)/read(0)
//   req_addr_i/req_wr_data_i: per-requester address and write data
//   req_ready_o/req_err_o   : per-requester retire pulse, abort flag
//   req_rd_data_o           : read data in the retire cycle of a read
//   gnt_o                   : one-hot current grant
//   mem_*                   : memory port, payload muxed from the grantee
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int TIMEOUT    = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid_i,
  input  logic [1:0]                 req_wr_rd_i,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr_i,
  input  logic [1:0][WIDTH-1:0]      req_wr_data_i,
  output logic [1:0]                 req_ready_o,
  output logic [1:0]                 req_err_o,
  output logic [WIDTH-1:0]           req_rd_data_o,
  output logic [1:0]                 gnt_o,
  output logic                       mem_valid_o,
  output logic                       mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0]      mem_addr_o,
  output logic [WIDTH-1:0]           mem_wr_data_o,
  input  logic                       mem_ready_i,
  input  logic [WIDTH-1:0]           mem_rd_data_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t       state, next_state;
  logic             ptr, next_ptr;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             granted;
  logic             cur;
  logic             expired;
  logic             retire;
  logic             arb_ptr;
  logic [1:0]       pick;

  assign granted = (state == GNT0) || (state == GNT1);
  assign cur     = (state == GNT1);
  assign expired = granted && !mem_ready_i && (cnt == CNT_W'(TIMEOUT - 1));
  assign retire  = granted && (mem_ready_i || expired);

  // On retirement the pointer moves to the other requester in the same edge,
  // so the pick is made with the already-advanced preference. That yields
  // "other if valid, else the same one again" without a second arbiter.
  assign arb_ptr = granted ? ~cur : ptr;

  rr_arb2 u_rr (
    .valid (req_valid_i),
    .ptr   (arb_ptr),
    .gnt   (pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= 1'(REQ0);
      cnt   <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
      cnt   <= next_cnt;
    end
  end

  // The counter only ever runs while a grant is waiting on the memory; it is
  // cleared on any retirement (handshake or abort) and while idle.
  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        next_cnt = '0;
        if (pick[REQ0]) begin
          next_state = GNT0;
        end else if (pick[REQ1]) begin
          next_state = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (retire) begin
          next_cnt = '0;
          next_ptr = ~cur;
          if (pick[REQ0]) begin
            next_state = GNT0;
          end else if (pick[REQ1]) begin
            next_state = GNT1;
          end else begin
            next_state = IDLE;
          end
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  assign gnt_o         = granted ? onehot2(cur) : 2'b00;
  assign mem_valid_o   = granted;
  assign mem_wr_rd_o   = granted ? req_wr_rd_i[cur] : 1'b0;
  assign mem_addr_o    = granted ? req_addr_i[cur] : '0;
  assign mem_wr_data_o = granted ? req_wr_data_i[cur] : '0;

  assign req_ready_o   = retire ? onehot2(cur) : 2'b00;
  assign req_err_o     = expired ? onehot2(cur) : 2'b00;
  assign req_rd_data_o = (granted && mem_ready_i) ? mem_rd_data_i : '0;

endmodule
